// File: rtl/mux_sel_scheduler.sv
// rtl/mux_sel_scheduler.sv - round-robin 4:1 mux select generator with dwell hold and break cycle
module mux_sel_scheduler #(
    parameter int DWELL_W = 4,
    parameter int SLOT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               sel_valid,
    output logic [3:0]         grant,
    output logic               slot_done,
    output logic [SLOT_W-1:0]  slot_count
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         last;
    logic [1:0]         winner;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic               grant_go;
    logic               hold_exit;

    // Scan from farthest to nearest so the nearest requester after last wins;
    // offset 4 wraps onto last itself, making it the lowest-priority candidate.
    always_comb begin
        winner = last;
        for (int k = 4; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                winner = last + 2'(k);
            end
        end
    end

    assign grant_go  = en && (|req);
    assign hold_exit = (cnt == dwell_q) || !req[sel] || !en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = grant_go ? S_HOLD : S_IDLE;
            S_HOLD:  state_nxt = hold_exit ? S_GAP : S_HOLD;
            S_GAP:   state_nxt = grant_go ? S_HOLD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel        <= 2'd0;
            last       <= 2'd3;
            cnt        <= '0;
            dwell_q    <= DWELL_W'(1);
            slot_count <= '0;
        end else if (state == S_HOLD) begin
            if (hold_exit) begin
                slot_count <= slot_count + SLOT_W'(1);
            end else begin
                cnt <= cnt + DWELL_W'(1);
            end
        end else if (grant_go) begin
            sel     <= winner;
            last    <= winner;
            cnt     <= DWELL_W'(1);
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
        end
    end

    always_comb begin
        sel_valid = (state == S_HOLD);
        grant     = sel_valid ? (4'b0001 << sel) : 4'b0000;
        slot_done = (state == S_GAP);
    end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// tb/tb_mux_sel_scheduler.sv - scoreboard bench for mux_sel_scheduler against a countdown model
module tb_mux_sel_scheduler;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] dwell;
    logic [1:0] sel;
    logic       sel_valid;
    logic [3:0] grant;
    logic       slot_done;
    logic [7:0] slot_count;

    typedef struct {
        int sel;
        int sel_valid;
        int grant;
        int slot_done;
        int slot_count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: phase 0=idle 1=hold 2=gap; m_left counts remaining valid cycles down.
    int m_phase = 0;
    int m_sel   = 0;
    int m_last  = 3;
    int m_left  = 0;
    int m_count = 0;

    mux_sel_scheduler #(.DWELL_W(4), .SLOT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .dwell(dwell),
        .sel(sel), .sel_valid(sel_valid), .grant(grant),
        .slot_done(slot_done), .slot_count(slot_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int rq, input int dw);
        exp_t x;
        int   pick;
        if (r) begin
            m_phase = 0; m_sel = 0; m_last = 3; m_count = 0;
        end else if (m_phase == 1) begin
            if (m_left == 1 || rq[m_sel] == 0 || !e) begin
                m_phase = 2;
                m_count = (m_count + 1) % 256;
            end else begin
                m_left = m_left - 1;
            end
        end else if (e && rq != 0) begin
            pick = -1;
            for (int k = 1; k <= 4; k++) begin
                if (pick < 0 && rq[(m_last + k) % 4]) pick = (m_last + k) % 4;
            end
            m_sel = pick; m_last = pick; m_phase = 1;
            m_left = (dw == 0) ? 1 : dw;
        end else begin
            m_phase = 0;
        end
        x.sel        = m_sel;
        x.sel_valid  = (m_phase == 1) ? 1 : 0;
        x.grant      = (m_phase == 1) ? (1 << m_sel) : 0;
        x.slot_done  = (m_phase == 2) ? 1 : 0;
        x.slot_count = m_count;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input logic [3:0] rq, input logic [3:0] dw, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; en = e; req = rq; dwell = dw;
            model_step(r, e, int'(rq), int'(dw));
        end
    endtask

    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("sel",        int'(sel),        x.sel);
            check("sel_valid",  int'(sel_valid),  x.sel_valid);
            check("grant",      int'(grant),      x.grant);
            check("slot_done",  int'(slot_done),  x.slot_done);
            check("slot_count", int'(slot_count), x.slot_count);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'b0; dwell = 4'd0;
        cyc(1, 0, 4'b0000, 4'd0, 2);
        // single requester, dwell 3
        cyc(0, 1, 4'b0100, 4'd3, 6);
        cyc(0, 1, 4'b0000, 4'd3, 2);
        // all requesting, dwell 2: full rotation
        cyc(0, 1, 4'b1111, 4'd2, 16);
        cyc(0, 1, 4'b0000, 4'd2, 2);
        // dwell 0 treated as 1, sole requester re-granted
        cyc(0, 1, 4'b0010, 4'd0, 7);
        cyc(0, 1, 4'b0000, 4'd0, 2);
        // ch3 with long dwell, request dropped early, ch0 takes over
        cyc(0, 1, 4'b1000, 4'd8, 2);
        cyc(0, 1, 4'b0001, 4'd8, 5);
        cyc(0, 1, 4'b0000, 4'd8, 2);
        // en dropped mid-hold on ch1, then rotation wraps to ch0
        cyc(0, 1, 4'b0011, 4'd8, 3);
        cyc(0, 0, 4'b0011, 4'd8, 3);
        cyc(0, 1, 4'b0011, 4'd8, 3);
        cyc(0, 1, 4'b0000, 4'd8, 2);
        // slot_count wrap through many short grants
        cyc(0, 1, 4'b0001, 4'd1, 540);
        // reset mid-hold
        cyc(0, 1, 4'b0100, 4'd9, 4);
        cyc(1, 1, 4'b0100, 4'd9, 1);
        cyc(0, 0, 4'b0000, 4'd9, 2);
        // random traffic with occasional reset and dwell changes mid-hold
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
        end
        cyc(0, 0, 4'b0000, 4'd0, 3);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
